// File: rtl/rob_ingress_arbiter_pkg.sv
// Shared types and constants for the ROB ingress link arbiter.
// Payload layouts stay in package Packet; nothing here looks inside a beat.
package rob_ingress_arbiter_pkg;

  typedef enum logic {
    SRC_DECODER = 1'b0,
    SRC_RRU     = 1'b1
  } PacketSource_T;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOCK_DEC = 2'd1,
    ST_LOCK_RRU = 2'd2
  } RobIngressState_T;

  localparam int unsigned ROB_PKT_W        = 32;
  localparam int unsigned DEC_TO_ROB_BEATS = 4;
  localparam int unsigned RRU_TO_ROB_BEATS = 2;

  // Index of the closing beat of a message of the given length.
  function automatic logic [1:0] final_beat_idx(input int unsigned beats);
    return 2'(beats - 1);
  endfunction

endpackage

// File: rtl/rob_ingress_stage.sv
// One-entry registered valid/ready slice feeding the ROB ingress link.
// Carries payload plus source, beat index and last-beat tag.
module rob_ingress_stage
  import rob_ingress_arbiter_pkg::*;
#(
  parameter int unsigned PKT_W = ROB_PKT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [PKT_W-1:0] data_i,
  input  PacketSource_T    src_i,
  input  logic [1:0]       beat_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [PKT_W-1:0] data_o,
  output PacketSource_T    src_o,
  output logic [1:0]       beat_o,
  output logic             last_o
);

  logic             valid_q, valid_d;
  logic [PKT_W-1:0] data_q,  data_d;
  PacketSource_T    src_q,   src_d;
  logic [1:0]       beat_q,  beat_d;
  logic             last_q,  last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    beat_d  = beat_q;
    last_d  = last_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      // A load replaces the entry even when it drains this same edge.
      valid_d = 1'b1;
      data_d  = data_i;
      src_d   = src_i;
      beat_d  = beat_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= SRC_DECODER;
      beat_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign src_o   = src_q;
  assign beat_o  = beat_q;
  assign last_o  = last_q;

endmodule

// File: rtl/rob_ingress_arbiter.sv
// Round-robin, message-granular arbiter sharing the ROB ingress link between
// the decoder (4-beat messages) and the register renaming unit (2-beat messages).
module rob_ingress_arbiter
  import rob_ingress_arbiter_pkg::*;
#(
  parameter int unsigned PKT_W     = ROB_PKT_W,
  parameter int unsigned DEC_BEATS = DEC_TO_ROB_BEATS,
  parameter int unsigned RRU_BEATS = RRU_TO_ROB_BEATS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             dec_valid,
  input  logic [PKT_W-1:0] dec_data,
  output logic             dec_ready,
  input  logic             rru_valid,
  input  logic [PKT_W-1:0] rru_data,
  output logic             rru_ready,
  output logic             out_valid,
  output logic [PKT_W-1:0] out_data,
  output logic             out_src,
  output logic [1:0]       out_beat,
  output logic             out_last,
  input  logic             out_ready
);

  RobIngressState_T state_q, state_d;
  logic [1:0]       beat_q, beat_d;
  PacketSource_T    last_grant_q, last_grant_d;

  logic             stage_free;
  logic             grant_vld;
  PacketSource_T    grant_src;
  logic             open;
  logic             accept;
  logic [PKT_W-1:0] load_data;
  logic [1:0]       load_beat;
  logic             load_last;
  PacketSource_T    out_src_e;

  assign stage_free = !out_valid || out_ready;

  // A locked source keeps the grant even while its valid is low.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = SRC_DECODER;
    unique case (state_q)
      ST_IDLE: begin
        if (dec_valid && rru_valid) begin
          grant_vld = 1'b1;
          grant_src = (last_grant_q == SRC_RRU) ? SRC_DECODER : SRC_RRU;
        end else if (dec_valid) begin
          grant_vld = 1'b1;
          grant_src = SRC_DECODER;
        end else if (rru_valid) begin
          grant_vld = 1'b1;
          grant_src = SRC_RRU;
        end
      end
      ST_LOCK_DEC: begin
        grant_vld = 1'b1;
        grant_src = SRC_DECODER;
      end
      ST_LOCK_RRU: begin
        grant_vld = 1'b1;
        grant_src = SRC_RRU;
      end
      default: ;
    endcase
  end

  assign open      = rst_n && !flush && stage_free && grant_vld;
  assign dec_ready = open && (grant_src == SRC_DECODER);
  assign rru_ready = open && (grant_src == SRC_RRU);
  assign accept    = (dec_valid && dec_ready) || (rru_valid && rru_ready);

  assign load_data = (grant_src == SRC_RRU) ? rru_data : dec_data;
  assign load_beat = (state_q == ST_IDLE) ? '0 : beat_q;
  assign load_last = (load_beat == ((grant_src == SRC_RRU) ? final_beat_idx(RRU_BEATS)
                                                           : final_beat_idx(DEC_BEATS)));

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      state_d = ST_IDLE;
      beat_d  = '0;
    end else if (accept) begin
      if (state_q == ST_IDLE) begin
        last_grant_d = grant_src;
      end
      if (load_last) begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end else begin
        state_d = (grant_src == SRC_RRU) ? ST_LOCK_RRU : ST_LOCK_DEC;
        beat_d  = load_beat + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      last_grant_q <= SRC_RRU;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
    end
  end

  rob_ingress_stage #(
    .PKT_W (PKT_W)
  ) u_stage (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .load_i  (accept),
    .data_i  (load_data),
    .src_i   (grant_src),
    .beat_i  (load_beat),
    .last_i  (load_last),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .src_o   (out_src_e),
    .beat_o  (out_beat),
    .last_o  (out_last)
  );

  assign out_src = out_src_e;

endmodule
